// File: rtl/load_store_buffer.sv
// In-order load/store queue: entries snoop operand broadcasts, the head issues one
// memory access at a time, and completions are broadcast back to the ROB.
module load_store_buffer #(
  parameter int unsigned LSB_WIDTH = 3,
  parameter int unsigned LSB_SIZE  = 2 ** LSB_WIDTH,
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic                 addValid,
  input  logic                 addIsStore,
  input  logic [2:0]           addFunct3,
  input  logic [ROB_WIDTH-1:0] addRobIndex,
  input  logic [31:0]          addOffset,
  input  logic                 addBaseReady,
  input  logic [31:0]          addBaseVal,
  input  logic [ROB_WIDTH-1:0] addBaseDep,
  input  logic                 addDataReady,
  input  logic [31:0]          addDataVal,
  input  logic [ROB_WIDTH-1:0] addDataDep,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic [ROB_WIDTH-1:0] robBeginId,
  input  logic                 writeValid,
  output logic                 lsbUpdate,
  output logic [ROB_WIDTH-1:0] lsbRobIndex,
  output logic [31:0]          lsbUpdateVal,
  output logic                 memValid,
  output logic                 memWrite,
  output logic [31:0]          memAddr,
  output logic [1:0]           memSize,
  output logic [31:0]          memWriteData,
  input  logic                 memDone,
  input  logic [31:0]          memReadData
);

  localparam int unsigned CNT_W = LSB_WIDTH + 1;

  typedef struct packed {
    logic                 valid;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [ROB_WIDTH-1:0] rob;
    logic [31:0]          offset;
    logic                 base_rdy;
    logic [31:0]          base_val;
    logic [ROB_WIDTH-1:0] base_dep;
    logic                 data_rdy;
    logic [31:0]          data_val;
    logic [ROB_WIDTH-1:0] data_dep;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

  state_t               state_q, state_d;
  entry_t               ent_q [LSB_SIZE];
  entry_t               ent_d [LSB_SIZE];
  logic [LSB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 drain_q, drain_d;
  logic                 full_q, full_d;
  logic                 lsb_upd_q, lsb_upd_d;
  logic [ROB_WIDTH-1:0] lsb_rob_q, lsb_rob_d;
  logic [31:0]          lsb_val_q, lsb_val_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  entry_t head_e, new_e;
  logic   issue_ok, push, pop;

  // Capture any operand whose producer tag matches a broadcast this cycle.
  function automatic entry_t wake(input entry_t e,
                                  input logic rs_v, input logic [ROB_WIDTH-1:0] rs_tag,
                                  input logic [31:0] rs_val,
                                  input logic l_v, input logic [ROB_WIDTH-1:0] l_tag,
                                  input logic [31:0] l_val);
    entry_t r;
    r = e;
    if (!r.base_rdy) begin
      if (rs_v && rs_tag == r.base_dep) begin
        r.base_rdy = 1'b1;
        r.base_val = rs_val;
      end else if (l_v && l_tag == r.base_dep) begin
        r.base_rdy = 1'b1;
        r.base_val = l_val;
      end
    end
    if (!r.data_rdy) begin
      if (rs_v && rs_tag == r.data_dep) begin
        r.data_rdy = 1'b1;
        r.data_val = rs_val;
      end else if (l_v && l_tag == r.data_dep) begin
        r.data_rdy = 1'b1;
        r.data_val = l_val;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    drain_d     = drain_q;
    lsb_upd_d   = 1'b0;
    lsb_rob_d   = lsb_rob_q;
    lsb_val_d   = lsb_val_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    push        = 1'b0;
    pop         = 1'b0;
    head_e      = ent_q[head_q];
    issue_ok    = head_e.valid && head_e.base_rdy &&
                  (!head_e.is_store ||
                   (head_e.data_rdy && writeValid && head_e.rob == robBeginId));

    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.is_store = addIsStore;
    new_e.funct3   = addFunct3;
    new_e.rob      = addRobIndex;
    new_e.offset   = addOffset;
    new_e.base_rdy = addBaseReady;
    new_e.base_val = addBaseVal;
    new_e.base_dep = addBaseDep;
    new_e.data_rdy = addDataReady;
    new_e.data_val = addDataVal;
    new_e.data_dep = addDataDep;
    new_e = wake(new_e, rsUpdate, rsRobIndex, rsUpdateVal, lsb_upd_q, lsb_rob_q, lsb_val_q);

    case (state_q)
      S_IDLE: begin
        if (issue_ok && !clearIn) begin
          state_d     = S_WAIT_MEM;
          mem_valid_d = 1'b1;
          mem_write_d = head_e.is_store;
          mem_addr_d  = head_e.base_val + head_e.offset;
          mem_size_d  = head_e.funct3[1:0];
          mem_wdata_d = head_e.data_val;
        end
      end
      S_WAIT_MEM: begin
        // A flushed store is already committed, so it keeps driving memory until done.
        if (clearIn && mem_write_q && !memDone) begin
          drain_d = 1'b1;
        end else if (clearIn || memDone) begin
          state_d     = S_IDLE;
          mem_valid_d = 1'b0;
          drain_d     = 1'b0;
          if (!clearIn && !drain_q) begin
            pop       = 1'b1;
            lsb_upd_d = 1'b1;
            lsb_rob_d = head_e.rob;
            lsb_val_d = head_e.is_store ? 32'd0 : load_ext(head_e.funct3, memReadData);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      if (ent_d[i].valid) begin
        ent_d[i] = wake(ent_d[i], rsUpdate, rsRobIndex, rsUpdateVal,
                        lsb_upd_q, lsb_rob_q, lsb_val_q);
      end
    end

    if (clearIn) begin
      for (int unsigned i = 0; i < LSB_SIZE; i++) begin
        ent_d[i].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + LSB_WIDTH'(1);
      end
      push = addValid && !drain_q && ((count_q < CNT_W'(LSB_SIZE)) || pop);
      if (push) begin
        ent_d[tail_q] = new_e;
        tail_d = tail_q + LSB_WIDTH'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // One slot of slack covers a dispatch already in flight upstream.
    full_d = (count_d >= CNT_W'(LSB_SIZE - 1)) || drain_d;
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      drain_q     <= 1'b0;
      full_q      <= 1'b0;
      lsb_upd_q   <= 1'b0;
      lsb_rob_q   <= '0;
      lsb_val_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      for (int unsigned i = 0; i < LSB_SIZE; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      drain_q     <= drain_d;
      full_q      <= full_d;
      lsb_upd_q   <= lsb_upd_d;
      lsb_rob_q   <= lsb_rob_d;
      lsb_val_q   <= lsb_val_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      ent_q       <= ent_d;
    end
  end

  assign full         = full_q;
  assign lsbUpdate    = lsb_upd_q;
  assign lsbRobIndex  = lsb_rob_q;
  assign lsbUpdateVal = lsb_val_q;
  assign memValid     = mem_valid_q;
  assign memWrite     = mem_write_q;
  assign memAddr      = mem_addr_q;
  assign memSize      = mem_size_q;
  assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based behavioural model.
module tb_load_store_buffer;

  logic        clk;
  logic        resetIn, clearIn, addValid, addIsStore;
  logic [2:0]  addFunct3;
  logic [3:0]  addRobIndex, addBaseDep, addDataDep, rsRobIndex, robBeginId, lsbRobIndex;
  logic [31:0] addOffset, addBaseVal, addDataVal, rsUpdateVal, lsbUpdateVal;
  logic        addBaseReady, addDataReady, full, rsUpdate, writeValid, lsbUpdate;
  logic        memValid, memWrite, memDone;
  logic [31:0] memAddr, memWriteData, memReadData;
  logic [1:0]  memSize;

  load_store_buffer dut (
    .clockIn(clk), .resetIn(resetIn), .clearIn(clearIn), .addValid(addValid),
    .addIsStore(addIsStore), .addFunct3(addFunct3), .addRobIndex(addRobIndex),
    .addOffset(addOffset), .addBaseReady(addBaseReady), .addBaseVal(addBaseVal),
    .addBaseDep(addBaseDep), .addDataReady(addDataReady), .addDataVal(addDataVal),
    .addDataDep(addDataDep), .full(full), .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex),
    .rsUpdateVal(rsUpdateVal), .robBeginId(robBeginId), .writeValid(writeValid),
    .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
    .memValid(memValid), .memWrite(memWrite), .memAddr(memAddr), .memSize(memSize),
    .memWriteData(memWriteData), .memDone(memDone), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        is_store;
    bit [2:0]  f3;
    bit [3:0]  rob;
    bit [31:0] off;
    bit        brdy;
    bit [31:0] bval;
    bit [3:0]  bdep;
    bit        drdy;
    bit [31:0] dval;
    bit [3:0]  ddep;
  } m_ent_t;

  m_ent_t    mq[$];
  bit        m_busy, m_drain;
  bit        e_full, e_lsbUpd, e_memValid, e_memWrite;
  bit [3:0]  e_lsbRob;
  bit [31:0] e_lsbVal, e_memAddr, e_memWdata;
  bit [1:0]  e_memSize;
  bit        mv_upd, mv_pop, mv_was_drain;
  bit [3:0]  mv_rob;
  bit [31:0] mv_val;
  m_ent_t    mv_new;

  function automatic bit [31:0] m_ext(input bit [2:0] f3, input bit [31:0] d);
    bit [31:0] mask, v;
    case (f3[1:0])
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    v = d & mask;
    if (!f3[2] && f3[1:0] != 2'd2 && (v & ((mask >> 1) + 32'd1)) != 32'd0) v = v | ~mask;
    return v;
  endfunction

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r = e;
    if (!r.brdy && rsUpdate && rsRobIndex == r.bdep) begin r.brdy = 1; r.bval = rsUpdateVal; end
    else if (!r.brdy && e_lsbUpd && e_lsbRob == r.bdep) begin r.brdy = 1; r.bval = e_lsbVal; end
    if (!r.drdy && rsUpdate && rsRobIndex == r.ddep) begin r.drdy = 1; r.dval = rsUpdateVal; end
    else if (!r.drdy && e_lsbUpd && e_lsbRob == r.ddep) begin r.drdy = 1; r.dval = e_lsbVal; end
    return r;
  endfunction

  function automatic bit m_eligible(input m_ent_t e);
    return e.brdy && (!e.is_store || (e.drdy && writeValid && e.rob == robBeginId));
  endfunction

  always @(posedge clk) begin
    if (resetIn) begin
      mq.delete();
      m_busy = 0; m_drain = 0; e_full = 0; e_lsbUpd = 0; e_lsbRob = 0; e_lsbVal = 0;
      e_memValid = 0; e_memWrite = 0; e_memAddr = 0; e_memSize = 0; e_memWdata = 0;
    end else begin
      mv_upd = 0; mv_pop = 0; mv_was_drain = m_drain; mv_rob = 0; mv_val = 0;
      if (!m_busy) begin
        if (!clearIn && mq.size() > 0 && m_eligible(mq[0])) begin
          m_busy = 1; e_memValid = 1; e_memWrite = mq[0].is_store;
          e_memAddr = mq[0].bval + mq[0].off; e_memSize = mq[0].f3[1:0];
          e_memWdata = mq[0].dval;
        end
      end else if (clearIn) begin
        if (e_memWrite && !memDone) m_drain = 1;
        else begin m_busy = 0; e_memValid = 0; m_drain = 0; end
      end else if (memDone) begin
        m_busy = 0; e_memValid = 0;
        if (!m_drain) begin
          mv_upd = 1; mv_pop = 1; mv_rob = mq[0].rob;
          mv_val = mq[0].is_store ? 32'd0 : m_ext(mq[0].f3, memReadData);
        end
        m_drain = 0;
      end
      foreach (mq[i]) mq[i] = m_wake(mq[i]);
      if (clearIn) mq.delete();
      else begin
        if (mv_pop) void'(mq.pop_front());
        if (addValid && !mv_was_drain) begin
          mv_new.is_store = addIsStore; mv_new.f3 = addFunct3; mv_new.rob = addRobIndex;
          mv_new.off = addOffset; mv_new.brdy = addBaseReady; mv_new.bval = addBaseVal;
          mv_new.bdep = addBaseDep; mv_new.drdy = addDataReady; mv_new.dval = addDataVal;
          mv_new.ddep = addDataDep;
          mq.push_back(m_wake(mv_new));
        end
      end
      e_lsbUpd = mv_upd;
      if (mv_upd) begin e_lsbRob = mv_rob; e_lsbVal = mv_val; end
      e_full = (mq.size() >= 7) || m_drain;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("full", full, e_full);
      chk("lsbUpdate", lsbUpdate, e_lsbUpd);
      chk("memValid", memValid, e_memValid);
      if (e_lsbUpd) begin
        chk("lsbRobIndex", lsbRobIndex, e_lsbRob);
        chk("lsbUpdateVal", lsbUpdateVal, e_lsbVal);
      end
      if (e_memValid) begin
        chk("memWrite", memWrite, e_memWrite);
        chk("memAddr", memAddr, e_memAddr);
        chk("memSize", memSize, e_memSize);
        if (e_memWrite) chk("memWriteData", memWriteData, e_memWdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input bit st, input bit [2:0] f3, input bit [3:0] rob,
                         input bit [31:0] off, input bit br, input bit [31:0] bv,
                         input bit [3:0] bd, input bit dr, input bit [31:0] dv,
                         input bit [3:0] dd);
    addIsStore = st; addFunct3 = f3; addRobIndex = rob; addOffset = off;
    addBaseReady = br; addBaseVal = bv; addBaseDep = bd;
    addDataReady = dr; addDataVal = dv; addDataDep = dd;
  endtask

  task automatic disp(input bit st, input bit [2:0] f3, input bit [3:0] rob,
                      input bit [31:0] off, input bit br, input bit [31:0] bv,
                      input bit [3:0] bd, input bit dr, input bit [31:0] dv,
                      input bit [3:0] dd);
    set_add(st, f3, rob, off, br, bv, bd, dr, dv, dd);
    addValid = 1;
    tick();
    addValid = 0;
  endtask

  task automatic wait_mem(input string nm);
    int k = 0;
    while (memValid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_issue"}, memValid, 1);
  endtask

  task automatic done_pulse(input bit [31:0] d);
    memDone = 1;
    memReadData = d;
    tick();
    memDone = 0;
  endtask

  bit [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int       ord [7] = '{9, 10, 11, 12, 13, 14, 7};
  bit [3:0] next_rob;

  initial begin
    resetIn = 1; clearIn = 0; addValid = 0; rsUpdate = 0; rsRobIndex = 0; rsUpdateVal = 0;
    robBeginId = 0; writeValid = 0; memDone = 0; memReadData = 0;
    set_add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    resetIn = 0;
    chk("rst_full", full, 0);
    chk("rst_lsbUpdate", lsbUpdate, 0);
    chk("rst_lsbRobIndex", lsbRobIndex, 0);
    chk("rst_lsbUpdateVal", lsbUpdateVal, 0);
    chk("rst_memValid", memValid, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memSize", memSize, 0);
    chk("rst_memWriteData", memWriteData, 0);
    chk_en = 1;

    // LW
    disp(0, 3'd2, 4'd1, 32'd4, 1, 32'h100, 0, 1, 0, 0);
    wait_mem("lw");
    chk("lw_addr", memAddr, 32'h104);
    chk("lw_size", memSize, 2'b10);
    chk("lw_write", memWrite, 0);
    done_pulse(32'hDEADBEEF);
    chk("lw_upd", lsbUpdate, 1);
    chk("lw_val", lsbUpdateVal, 32'hDEADBEEF);
    chk("lw_rob", lsbRobIndex, 1);
    chk("lw_vdrop", memValid, 0);
    tick();
    chk("lw_pulse", lsbUpdate, 0);

    // LB / LBU on 0x80
    disp(0, 3'd0, 4'd2, 32'd1, 1, 32'h40, 0, 0, 0, 0);
    wait_mem("lb");
    done_pulse(32'h0000_0080);
    chk("lb_val", lsbUpdateVal, 32'hFFFF_FF80);
    disp(0, 3'd4, 4'd3, 32'd1, 1, 32'h40, 0, 0, 0, 0);
    wait_mem("lbu");
    done_pulse(32'h0000_0080);
    chk("lbu_val", lsbUpdateVal, 32'h0000_0080);

    // SW waits for ROB head
    robBeginId = 3; writeValid = 1;
    disp(1, 3'd2, 4'd5, 32'h8, 1, 32'h400, 0, 1, 32'hCAFEF00D, 0);
    repeat (4) tick();
    chk("sw_hold", memValid, 0);
    robBeginId = 5;
    wait_mem("sw");
    chk("sw_write", memWrite, 1);
    chk("sw_addr", memAddr, 32'h408);
    chk("sw_data", memWriteData, 32'hCAFEF00D);
    done_pulse(32'h1234_5678);
    chk("sw_upd", lsbUpdate, 1);
    chk("sw_val", lsbUpdateVal, 0);
    chk("sw_rob", lsbRobIndex, 5);

    // same-cycle wakeup on dispatch
    rsUpdate = 1; rsRobIndex = 7; rsUpdateVal = 32'h200;
    disp(0, 3'd2, 4'd6, 32'h10, 0, 0, 4'd7, 0, 0, 0);
    rsUpdate = 0;
    wait_mem("dep");
    chk("dep_addr", memAddr, 32'h210);
    done_pulse(32'h0);

    // fill to full across the wrap, push+pop at full, FIFO order
    disp(0, 3'd2, 4'd8, 0, 1, 32'h1000, 0, 0, 0, 0);
    for (int i = 9; i < 15; i++) disp(0, 3'd2, 4'(i), 32'(i * 4), 0, 0, 4'd15, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_busy", memValid, 1);
    set_add(0, 3'd2, 4'd7, 32'h4, 1, 32'h3000, 0, 0, 0, 0);
    addValid = 1; memDone = 1; memReadData = 32'h55;
    tick();
    addValid = 0; memDone = 0;
    chk("pp_full", full, 1);
    chk("pp_upd", lsbUpdate, 1);
    chk("pp_rob", lsbRobIndex, 8);
    rsUpdate = 1; rsRobIndex = 15; rsUpdateVal = 32'h2000;
    tick();
    rsUpdate = 0;
    for (int i = 0; i < 7; i++) begin
      wait_mem("fifo");
      done_pulse($urandom);
      chk("fifo_order", lsbRobIndex, 32'(ord[i]));
    end
    tick();
    chk("fifo_empty_full", full, 0);

    // clear aborts an outstanding load
    disp(0, 3'd2, 4'd3, 0, 1, 32'h500, 0, 0, 0, 0);
    wait_mem("clrld");
    clearIn = 1;
    tick();
    clearIn = 0;
    chk("clrld_valid", memValid, 0);
    chk("clrld_upd", lsbUpdate, 0);
    chk("clrld_full", full, 0);
    repeat (3) tick();

    // clear with an outstanding store: drains silently
    robBeginId = 2;
    disp(1, 3'd2, 4'd2, 0, 1, 32'h300, 0, 1, 32'h1234_5678, 0);
    wait_mem("clrst");
    disp(0, 3'd2, 4'd4, 0, 0, 0, 4'd15, 0, 0, 0);
    clearIn = 1;
    tick();
    clearIn = 0;
    chk("clrst_valid", memValid, 1);
    chk("clrst_full", full, 1);
    repeat (3) tick();
    chk("clrst_full_hold", full, 1);
    chk("clrst_data_hold", memWriteData, 32'h1234_5678);
    done_pulse(32'h0);
    chk("clrst_vdrop", memValid, 0);
    chk("clrst_noupd", lsbUpdate, 0);
    chk("clrst_full_rel", full, 0);

    // random traffic
    next_rob = 0;
    for (int c = 0; c < 4000; c++) begin
      memDone = e_memValid && ($urandom_range(0, 2) == 0);
      memReadData = $urandom;
      writeValid = ($urandom_range(0, 7) != 0);
      robBeginId = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].rob : 4'($urandom);
      rsUpdate = ($urandom_range(0, 2) == 0);
      rsUpdateVal = $urandom;
      if (mq.size() > 0 && !mq[0].brdy) rsRobIndex = mq[0].bdep;
      else if (mq.size() > 0 && !mq[0].drdy) rsRobIndex = mq[0].ddep;
      else rsRobIndex = 4'($urandom);
      clearIn = ($urandom_range(0, 79) == 0);
      addValid = !e_full && ($urandom_range(0, 1) == 1);
      addIsStore = ($urandom_range(0, 2) == 0);
      addFunct3 = addIsStore ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      addRobIndex = next_rob;
      if (addValid) next_rob = next_rob + 4'd1;
      addOffset = $urandom;
      addBaseReady = ($urandom_range(0, 9) < 7);
      addBaseVal = $urandom;
      addBaseDep = 4'($urandom);
      addDataReady = ($urandom_range(0, 9) < 7);
      addDataVal = $urandom;
      addDataDep = 4'($urandom);
      tick();
    end
    addValid = 0; clearIn = 0; memDone = 0; rsUpdate = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
